// File: rtl/bus_rr_arb_mux.sv
// bus_rr_arb_mux
//   Round-robin arbiter for NUM_M bus masters plus the master-to-slave
//   multiplexer that drives the shared slave-side bus from the current owner.
//
//   Ports
//     clk          system clock, rising edge
//     reset_       asynchronous reset, active low
//     m_req_       per-master request, active low
//     m_addr       packed master addresses, master i at [i*ADDR_W +: ADDR_W]
//     m_as_        per-master address strobe, active low
//     m_rw         per-master direction, 1 = read, 0 = write
//     m_wr_data    packed master write data, master i at [i*DATA_W +: DATA_W]
//     m_grnt_      per-master grant, active low, registered, at most one low
//     s_addr       selected address       (0 when no grant)
//     s_as_        selected strobe        (1 when no grant)
//     s_rw         selected direction     (1 when no grant)
//     s_wr_data    selected write data    (0 when no grant)
//     owner        index of current owner, valid while busy
//     busy         1 while a grant is active
//     timeout_evt  one-cycle pulse on forced revocation (timeout build only)
//
//   Build option: define BUS_ARB_TIMEOUT_EN to add the tenure counter that
//   revokes ownership after TIMEOUT_CYCLES owned cycles when others wait.
//
//   state | meaning
//   IDLE  | no grant; scan requests from owner+1 each cycle
//   OWNED | one master holds the bus until it releases (or times out)

module bus_rr_arb_mux #(
   parameter int NUM_M          = 4,
   parameter int ADDR_W         = 30,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                        clk,
   input  logic                        reset_,
   input  logic [NUM_M-1:0]            m_req_,
   input  logic [NUM_M*ADDR_W-1:0]     m_addr,
   input  logic [NUM_M-1:0]            m_as_,
   input  logic [NUM_M-1:0]            m_rw,
   input  logic [NUM_M*DATA_W-1:0]     m_wr_data,
   output logic [NUM_M-1:0]            m_grnt_,
   output logic [ADDR_W-1:0]           s_addr,
   output logic                        s_as_,
   output logic                        s_rw,
   output logic [DATA_W-1:0]           s_wr_data,
   output logic [$clog2(NUM_M)-1:0]    owner,
   output logic                        busy
`ifdef BUS_ARB_TIMEOUT_EN
   ,
   output logic                        timeout_evt
`endif
);

   localparam int OW = $clog2(NUM_M);

   if (NUM_M < 2 || NUM_M > 16) begin : g_chk_num_m
      $error("NUM_M out of range");
   end
   if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_chk_timeout
      $error("TIMEOUT_CYCLES out of range");
   end

   typedef enum logic {IDLE, OWNED} state_t;

   state_t           state, state_nxt;
   logic [NUM_M-1:0] grnt, grnt_nxt;
   logic [OW-1:0]    owner_nxt;
   logic [NUM_M-1:0] req, scan_req;
   logic             hit;
   logic [OW-1:0]    hit_idx;

   // owner doubles as the round-robin pointer: it is loaded on every grant
   // and keeps the last owner through IDLE, so the scan always starts after it.
   function automatic logic [OW:0] rr_pick(input logic [NUM_M-1:0] r,
                                           input logic [OW-1:0]    base);
      logic          found;
      logic [OW-1:0] idx;
      int            j;
      found = 1'b0;
      idx   = '0;
      for (int k = 1; k <= NUM_M; k++) begin
         j = int'(base) + k;
         if (j >= NUM_M) j = j - NUM_M;
         if (!found && r[j]) begin
            found = 1'b1;
            idx   = OW'(j);
         end
      end
      return {found, idx};
   endfunction

`ifdef BUS_ARB_TIMEOUT_EN
   localparam logic [15:0] TENURE_MAX = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0] tenure, tenure_nxt;
   logic        evt_nxt;
`endif

   always_comb begin
      req       = ~m_req_;
      state_nxt = state;
      grnt_nxt  = grnt;
      owner_nxt = owner;
`ifdef BUS_ARB_TIMEOUT_EN
      tenure_nxt = tenure;
      evt_nxt    = 1'b0;
`endif
      // While owned the current owner never competes: on release its request
      // is already gone, and on a timeout it must be skipped.
      scan_req = req;
      if (state == OWNED) scan_req[owner] = 1'b0;
      {hit, hit_idx} = rr_pick(scan_req, owner);

      case (state)
         IDLE: begin
            if (hit) begin
               state_nxt = OWNED;
               grnt_nxt  = NUM_M'(1) << hit_idx;
               owner_nxt = hit_idx;
`ifdef BUS_ARB_TIMEOUT_EN
               tenure_nxt = '0;
`endif
            end
         end
         OWNED: begin
            if (!req[owner]) begin
               if (hit) begin
                  grnt_nxt  = NUM_M'(1) << hit_idx;
                  owner_nxt = hit_idx;
`ifdef BUS_ARB_TIMEOUT_EN
                  tenure_nxt = '0;
`endif
               end else begin
                  state_nxt = IDLE;
                  grnt_nxt  = '0;
               end
            end
`ifdef BUS_ARB_TIMEOUT_EN
            else if (tenure == TENURE_MAX) begin
               tenure_nxt = '0;
               if (hit) begin
                  grnt_nxt  = NUM_M'(1) << hit_idx;
                  owner_nxt = hit_idx;
                  evt_nxt   = 1'b1;
               end
            end else begin
               tenure_nxt = tenure + 16'd1;
            end
`endif
         end
         default: begin
            state_nxt = IDLE;
            grnt_nxt  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         state <= IDLE;
         grnt  <= '0;
         owner <= OW'(NUM_M - 1);
      end else begin
         state <= state_nxt;
         grnt  <= grnt_nxt;
         owner <= owner_nxt;
      end
   end

`ifdef BUS_ARB_TIMEOUT_EN
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         tenure      <= '0;
         timeout_evt <= 1'b0;
      end else begin
         tenure      <= tenure_nxt;
         timeout_evt <= evt_nxt;
      end
   end
`endif

   assign m_grnt_ = ~grnt;
   assign busy    = (state == OWNED);

   // grnt is one-hot or zero, so at most one branch below fires.
   always_comb begin
      s_addr    = '0;
      s_as_     = 1'b1;
      s_rw      = 1'b1;
      s_wr_data = '0;
      for (int i = 0; i < NUM_M; i++) begin
         if (grnt[i]) begin
            s_addr    = m_addr[i*ADDR_W +: ADDR_W];
            s_as_     = m_as_[i];
            s_rw      = m_rw[i];
            s_wr_data = m_wr_data[i*DATA_W +: DATA_W];
         end
      end
   end

endmodule

// File: doc/bus_rr_arb_mux.md
Name: bus_rr_arb_mux

Overview:
- Parametrised bus master arbiter plus master-to-slave multiplexer for N bus masters.
- Takes active-low requests from each master and issues one-hot active-low grants with round-robin fairness.
- Drives the selected master's address, strobe, direction and write data onto the shared slave-side bus.
- Sits between the masters (CPU fetch/data ports, DMA, debug) and the address decoder / slave mux.

Parameters:
- NUM_M, 4, number of masters (2..16).
- ADDR_W, 30, word address width.
- DATA_W, 32, data width.
- TIMEOUT_CYCLES, 256, maximum consecutive ownership cycles (used only with the optional feature; 2..65535).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_  in  1  asynchronous, active-low reset.
- m_req_  in  NUM_M  per-master bus request, active-low; bit i = master i.
- m_addr  in  NUM_M*ADDR_W  packed addresses; master i occupies [i*ADDR_W +: ADDR_W].
- m_as_  in  NUM_M  per-master address strobe, active-low.
- m_rw  in  NUM_M  per-master direction; 1 = READ, 0 = WRITE.
- m_wr_data  in  NUM_M*DATA_W  packed write data; master i occupies [i*DATA_W +: DATA_W].
- m_grnt_  out  NUM_M  per-master grant, active-low, registered; at most one bit low.
- s_addr  out  ADDR_W  selected address.
- s_as_  out  1  selected address strobe.
- s_rw  out  1  selected direction.
- s_wr_data  out  DATA_W  selected write data.
- owner  out  clog2(NUM_M)  index of the current owner, registered; valid only while busy = 1.
- busy  out  1  1 while any grant is active.

Behaviour:
- Reset (async, reset_ = 0):
  - m_grnt_ = all 1, busy = 0, owner = NUM_M-1.
  - Internal round-robin pointer = NUM_M-1, so master 0 has top priority first.
- States:
  - IDLE (busy = 0): each cycle, scan requests starting at pointer+1, wrapping modulo NUM_M. The first requester found is granted at the next edge.
    - Latency: req_ low in cycle t -> grnt_ low from edge t+1.
    - No request: stay IDLE.
  - OWNED (busy = 1): grant holds while the owner keeps req_ = 0. Requests from other masters are ignored.
- Release:
  - Owner raises req_ in cycle t. At edge t+1 the arbiter rescans from owner+1, the released owner having lowest priority.
  - If another master requests, ownership hands over directly at t+1: no idle cycle, no overlap, old grant deasserts on the same edge.
  - If no master requests, go to IDLE with all grants high.
- Pointer: loaded with the new owner index on every grant.
- Simultaneous events: release and new requests in the same cycle resolve per the rescan rule. Only the requests sampled in that cycle count.
- Slave-side mux: combinational from the registered grant.
  - No grant: s_addr = 0, s_as_ = 1, s_rw = 1 (READ), s_wr_data = 0.
  - Otherwise the owner's fields pass through unchanged, no added latency.
- Invariant: $countones(~m_grnt_) <= 1 in all cycles, including during reset.
- Reset mid-transfer: grant drops immediately (asynchronous) and the outputs return to the no-grant defaults.

Optional Feature:
- Macro: BUS_ARB_TIMEOUT_EN.
- When defined:
  - A 16-bit tenure counter clears on each new grant and increments every OWNED cycle.
  - When the counter reaches TIMEOUT_CYCLES-1 and another master requests, ownership is forcibly revoked at the next edge. The grant passes to the next requester by the rescan rule, with the current owner excluded.
  - If no other master requests, the owner keeps the bus and the counter restarts at 0.
  - Output timeout_evt (1 bit, registered) pulses high for one cycle on each forced revocation; it resets to 0.
- When undefined: no counter, no timeout_evt port, and ownership ends only on release.

Test Plan:
- Reset, then master 2 only pulls req_ low at cycle 5 -> m_grnt_ = 4'b1011 from cycle 6; s_addr = master 2 address; owner = 2; busy = 1.
- All four masters hold req_ low. Each owner releases after 3 cycles, then re-requests -> grant order 0,1,2,3,0 with zero idle cycles between tenures.
- Owner 1 releases with no other requester -> next edge m_grnt_ = 4'hF, busy = 0, s_as_ = 1, s_rw = 1, s_addr = 0, s_wr_data = 0.
- Owner 3 releases while masters 0 and 2 request -> master 0 granted (wrap from pointer 3).
- Assert reset_ low mid-cycle during an OWNED write -> m_grnt_ = 4'hF and s_as_ = 1 immediately; after release, master 0 wins first.
- With BUS_ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 8, master 0 holds while master 1 requests -> revocation after 8 owned cycles, m_grnt_ = 4'b1101, timeout_evt high for 1 cycle. With master 0 requesting alone -> no revocation.
